sdram_local_port_arbiter: RTL and testbench
===========================================

# sdram_local_port_arbiter

Parametrised N-port front end for the DDR SDRAM controller's local (Avalon-style) interface. It arbitrates read and write burst requests from `NUM_PORTS` masters onto the single controller local port. A tag FIFO records each accepted read and steers returned read data back to the port that issued it. It sits between system masters (Ethernet DMA, CPU, etc.) and the controller/PHY wrapper, in the controller clock domain.

## Interface
- `NUM_PORTS`, 4: number of master ports (2..8).
- `ADDR_W`, 24: local word-address width.
- `DATA_W`, 64: local data width; `BE_W = DATA_W/8`.
- `SIZE_W`, 3: burst-size width.
- `TAG_DEPTH`, 16: maximum number of outstanding reads (power of 2).
- `PRIORITY_MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- `clk` in 1: controller clock (phy_clk); single clock domain.
- `reset_n` in 1: reset, asynchronous, active-low.
- `port_address` in NUM_PORTS*ADDR_W: per-port address, port i at slice i.
- `port_read_req` / `port_write_req` in NUM_PORTS: per-port requests, held until accepted.
- `port_size` in NUM_PORTS*SIZE_W: burst length in beats.
- `port_burstbegin` in NUM_PORTS: ignored; the arbiter generates burstbegin itself.
- `port_be` in NUM_PORTS*BE_W; `port_wdata` in NUM_PORTS*DATA_W.
- `port_ready` out NUM_PORTS: beat/command accepted for port i.
- `port_rdata` out DATA_W: read data, broadcast to all ports.
- `port_rdata_valid` out NUM_PORTS: one-hot; marks the owner of the current read beat.
- `local_address`, `local_size`, `local_be`, `local_wdata`, `local_read_req`, `local_write_req`, `local_burstbegin` out: drive the controller.
- `local_ready`, `local_rdata`, `local_rdata_valid`, `local_init_done` in: from the controller.
- `grant_port` out $clog2(NUM_PORTS): currently granted port.
- `busy` out 1: state ≠ IDLE.
- `rd_orphan_err` out 1: sticky error flag.

## Operation
- FSM states: IDLE, WR, RD.
- **IDLE:** arbitrates only when `local_init_done` = 1.
  - A port is eligible if it has a write request, or a read request while tag count < TAG_DEPTH.
  - The winner is registered into `grant`. State moves to WR if the winner's write_req is set, otherwise RD. Write wins if a port asserts both.
- **Round-robin:** search starts at `last_grant`+1 modulo NUM_PORTS. `last_grant` is updated on each grant.
- **WR:**
  - `local_*` signals are combinationally muxed from the granted port.
  - `local_burstbegin` is 1 only on the first beat (beat_cnt = 0) while write_req is high.
  - A beat is accepted when `local_ready & local_write_req`. On acceptance, `port_ready[grant]` = 1 and `beat_cnt` increments.
  - When the last beat (beat_cnt = size−1) is accepted, return to IDLE.
  - Write_req deasserting mid-burst stalls the burst; the grant is kept.
- **RD:**
  - `local_read_req` and `local_burstbegin` are held until `local_ready`.
  - On acceptance: pulse `port_ready[grant]`, push {grant, size} into the tag FIFO, return to IDLE.
- **Size 0** is treated as 1, both for beat counting and for the forwarded `local_size`.
- **Read return:**
  - On `local_rdata_valid` with the FIFO non-empty: `port_rdata_valid[head.port]` = 1, `port_rdata` = `local_rdata`, and `rcnt` increments.
  - When rcnt = head.size−1: pop the head and clear rcnt.
- **Orphan data:** `local_rdata_valid` with the FIFO empty sets `rd_orphan_err`. The beat is dropped. The flag clears only on reset.
- **Simultaneous push and pop** in one cycle leaves the count unchanged. Because the push gate uses the count sampled in IDLE, the FIFO never overflows.

## Timing
- Reset values:
  - All `local_*` outputs, `port_ready`, `port_rdata_valid`, `busy` and `rd_orphan_err` = 0; `port_rdata` = 0.
  - FSM = IDLE, `grant` = 0, `last_grant` = NUM_PORTS−1 (port 0 first), tag FIFO empty, `beat_cnt` = `rcnt` = 0.
- Arbitration latency: a request seen in IDLE at cycle N reaches `local_*_req` at cycle N+1.
- Transactions have one IDLE bubble between them; minimum issue interval is 2 cycles for reads.
- Read return path is combinational: `port_rdata_valid` appears in the same cycle as `local_rdata_valid`. The outstanding-read limit is TAG_DEPTH.
- Reset asserted mid-burst aborts immediately. Outstanding read tags are discarded; a controller reset must accompany it.

## Structure
- Package `sdram_arb_pkg`: FSM state enum, tag struct {port, size}, and a `PORT_W = $clog2(NUM_PORTS)` helper function.
- Sub-module `sdram_arb_tag_fifo`: synchronous FIFO, width PORT_W+SIZE_W, depth TAG_DEPTH, with count/full/empty outputs and the same clk/reset_n.
- Top level contains the arbiter, FSM, beat counter and muxes.

## Test plan
- **Round-robin:** NUM_PORTS=4, ports 0–3 each issue a size-1 write simultaneously, `local_ready` = 1 → grants in order 0, 1, 2, 3; each `port_ready` pulses once; `local_burstbegin` on every beat.
- **Stalled write burst:** port 2 writes size 4, `local_ready` low on beat 2 for 3 cycles → 4 beats delivered in order, burstbegin only on beat 0, no other port is granted meanwhile.
- **Interleaved read return:** port 1 reads size 2, then port 3 reads size 4; controller returns 6 beats back-to-back → `port_rdata_valid` = 0010 ×2, then 1000 ×4; FIFO empty afterwards.
- **Tag limit:** TAG_DEPTH=4, port 0 issues 5 reads with no data returned → 4 accepted; 5th held until the first pop, then accepted.
- **Fixed priority and init gating:** PRIORITY_MODE=1, ports 0 and 3 requesting continuously with `local_init_done` = 0 → no grant; after init_done = 1, port 3 is starved.
- **Orphan and reset:** `local_rdata_valid` pulse with FIFO empty → `rd_orphan_err` = 1 and stays high; assert reset mid-burst → all outputs 0 asynchronously.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM local-port arbiter: FSM states, read tag layout
// and the port-index width helper.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } arb_state_e;

  // Tag fields are sized for the largest supported configuration (8 ports,
  // sizes up to 8 bits); narrower FIFO entries are zero-extended into them.
  localparam int unsigned TAG_PORT_W_MAX = 3;
  localparam int unsigned TAG_SIZE_W_MAX = 8;

  typedef struct packed {
    logic [TAG_PORT_W_MAX-1:0] port;
    logic [TAG_SIZE_W_MAX-1:0] size;
  } tag_t;

  function automatic int unsigned port_w(input int unsigned num_ports);
    return (num_ports < 2) ? 1 : $clog2(num_ports);
  endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Read-tag FIFO: remembers {port, size} of each accepted read so returned
// beats can be steered back to their owner.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW    = (DEPTH < 2) ? 1 : $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sdram_local_port_arbiter.sv
// N-port arbiter in front of the DDR SDRAM controller local port: grants one
// read or write burst at a time and routes returned read beats by tag.
module sdram_local_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS     = 4,
  parameter int unsigned ADDR_W        = 24,
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned SIZE_W        = 3,
  parameter int unsigned TAG_DEPTH     = 16,
  parameter int unsigned PRIORITY_MODE = 0,
  localparam int unsigned BE_W   = DATA_W / 8,
  localparam int unsigned PORT_W = port_w(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_address,
  input  logic [NUM_PORTS-1:0]          port_read_req,
  input  logic [NUM_PORTS-1:0]          port_write_req,
  input  logic [NUM_PORTS*SIZE_W-1:0]   port_size,
  input  logic [NUM_PORTS-1:0]          port_burstbegin,
  input  logic [NUM_PORTS*BE_W-1:0]     port_be,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_wdata,
  output logic [NUM_PORTS-1:0]          port_ready,
  output logic [DATA_W-1:0]             port_rdata,
  output logic [NUM_PORTS-1:0]          port_rdata_valid,
  output logic [ADDR_W-1:0]             local_address,
  output logic [SIZE_W-1:0]             local_size,
  output logic [BE_W-1:0]               local_be,
  output logic [DATA_W-1:0]             local_wdata,
  output logic                          local_read_req,
  output logic                          local_write_req,
  output logic                          local_burstbegin,
  input  logic                          local_ready,
  input  logic [DATA_W-1:0]             local_rdata,
  input  logic                          local_rdata_valid,
  input  logic                          local_init_done,
  output logic [PORT_W-1:0]             grant_port,
  output logic                          busy,
  output logic                          rd_orphan_err
);

  localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;
  localparam int unsigned TAG_W = PORT_W + SIZE_W;

  arb_state_e        state_q, state_d;
  logic [PORT_W-1:0] grant_q, grant_d;
  logic [PORT_W-1:0] last_grant_q, last_grant_d;
  logic [SIZE_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [SIZE_W-1:0] rcnt_q, rcnt_d;
  logic              orphan_q, orphan_d;

  logic [ADDR_W-1:0] addr_a  [NUM_PORTS];
  logic [SIZE_W-1:0] size_a  [NUM_PORTS];
  logic [BE_W-1:0]   be_a    [NUM_PORTS];
  logic [DATA_W-1:0] wdata_a [NUM_PORTS];
  logic [SIZE_W-1:0] g_size;

  logic [NUM_PORTS-1:0] eligible;
  logic                 tag_room;
  logic                 win_found;
  logic [PORT_W-1:0]    winner;
  logic [PORT_W-1:0]    rr_idx;

  logic             tag_push, tag_pop, tag_full, tag_empty;
  logic [TAG_W-1:0] tag_wdata, tag_rdata;
  logic [CNT_W-1:0] tag_count;
  tag_t             head;
  logic             rd_hit, rd_last;

  // The arbiter generates burstbegin itself; masters' copies are not used.
  logic unused_burstbegin;
  assign unused_burstbegin = ^port_burstbegin;

  function automatic logic [SIZE_W-1:0] size_or_one(input logic [SIZE_W-1:0] s);
    return (s == '0) ? SIZE_W'(1) : s;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      addr_a[i]  = port_address[i*ADDR_W +: ADDR_W];
      size_a[i]  = port_size[i*SIZE_W +: SIZE_W];
      be_a[i]    = port_be[i*BE_W +: BE_W];
      wdata_a[i] = port_wdata[i*DATA_W +: DATA_W];
    end
  end

  assign g_size = size_or_one(size_a[grant_q]);

  assign tag_room = (tag_count < CNT_W'(TAG_DEPTH));

  always_comb begin
    eligible  = port_write_req | (port_read_req & {NUM_PORTS{tag_room}});
    win_found = 1'b0;
    winner    = '0;
    rr_idx    = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (PRIORITY_MODE != 0) rr_idx = PORT_W'(k);
      else rr_idx = PORT_W'((32'(last_grant_q) + 32'd1 + k) % NUM_PORTS);
      if (!win_found && eligible[rr_idx]) begin
        win_found = 1'b1;
        winner    = rr_idx;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_grant_d     = last_grant_q;
    beat_cnt_d       = beat_cnt_q;
    local_address    = '0;
    local_size       = '0;
    local_be         = '0;
    local_wdata      = '0;
    local_read_req   = 1'b0;
    local_write_req  = 1'b0;
    local_burstbegin = 1'b0;
    port_ready       = '0;
    tag_push         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (local_init_done && win_found) begin
          grant_d      = winner;
          last_grant_d = winner;
          beat_cnt_d   = '0;
          state_d      = port_write_req[winner] ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        local_address    = addr_a[grant_q];
        local_size       = g_size;
        local_be         = be_a[grant_q];
        local_wdata      = wdata_a[grant_q];
        local_write_req  = port_write_req[grant_q];
        local_burstbegin = local_write_req && (beat_cnt_q == '0);
        if (local_ready && local_write_req) begin
          port_ready[grant_q] = 1'b1;
          if (beat_cnt_q == g_size - SIZE_W'(1)) begin
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + SIZE_W'(1);
          end
        end
      end
      ST_RD: begin
        local_address    = addr_a[grant_q];
        local_size       = g_size;
        local_read_req   = 1'b1;
        local_burstbegin = 1'b1;
        if (local_ready) begin
          port_ready[grant_q] = 1'b1;
          tag_push            = !tag_full;
          state_d             = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tag_wdata = {grant_q, g_size};

  sdram_arb_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (tag_push),
    .wdata_i (tag_wdata),
    .pop_i   (tag_pop),
    .rdata_o (tag_rdata),
    .count_o (tag_count),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  always_comb begin
    head                   = '0;
    head.port[PORT_W-1:0]  = tag_rdata[SIZE_W +: PORT_W];
    head.size[SIZE_W-1:0]  = tag_rdata[0 +: SIZE_W];
  end

  assign rd_hit  = local_rdata_valid && !tag_empty;
  assign rd_last = rd_hit && (head.size == TAG_SIZE_W_MAX'(rcnt_q) + TAG_SIZE_W_MAX'(1));
  assign tag_pop = rd_last;

  always_comb begin
    rcnt_d           = rcnt_q;
    orphan_d         = orphan_q | (local_rdata_valid && tag_empty);
    port_rdata       = rd_hit ? local_rdata : '0;
    port_rdata_valid = '0;
    if (rd_last)     rcnt_d = '0;
    else if (rd_hit) rcnt_d = rcnt_q + SIZE_W'(1);
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (rd_hit && (head.port == TAG_PORT_W_MAX'(i))) port_rdata_valid[i] = 1'b1;
    end
  end

  assign grant_port    = grant_q;
  assign busy          = (state_q != ST_IDLE);
  assign rd_orphan_err = orphan_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= PORT_W'(NUM_PORTS - 1);
      beat_cnt_q   <= '0;
      rcnt_q       <= '0;
      orphan_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      rcnt_q       <= rcnt_d;
      orphan_q     <= orphan_d;
    end
  end

endmodule

// File: tb/tb_sdram_local_port_arbiter.sv
// Directed bench for sdram_local_port_arbiter: round-robin and fixed-priority
// instances share stimulus; expected values are hand-derived per scenario.
module tb_sdram_local_port_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 3;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned PW = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic [NP*AW-1:0] port_address;
  logic [NP-1:0]    port_read_req, port_write_req, port_burstbegin;
  logic [NP*SW-1:0] port_size;
  logic [NP*BW-1:0] port_be;
  logic [NP*DW-1:0] port_wdata;
  logic             local_ready, local_rdata_valid, local_init_done;
  logic [DW-1:0]    local_rdata;

  logic [NP-1:0] a_port_ready, a_port_rdata_valid, b_port_ready, b_port_rdata_valid;
  logic [DW-1:0] a_port_rdata, a_local_wdata, b_port_rdata, b_local_wdata;
  logic [AW-1:0] a_local_address, b_local_address;
  logic [SW-1:0] a_local_size, b_local_size;
  logic [BW-1:0] a_local_be, b_local_be;
  logic          a_local_read_req, a_local_write_req, a_local_burstbegin;
  logic          b_local_read_req, b_local_write_req, b_local_burstbegin;
  logic [PW-1:0] a_grant_port, b_grant_port;
  logic          a_busy, a_rd_orphan_err, b_busy, b_rd_orphan_err;

  int n_checks;
  int n_errors;

  always #5 clk = ~clk;

  sdram_local_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW),
    .TAG_DEPTH(4), .PRIORITY_MODE(0)
  ) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .port_address(port_address), .port_read_req(port_read_req),
    .port_write_req(port_write_req), .port_size(port_size),
    .port_burstbegin(port_burstbegin), .port_be(port_be), .port_wdata(port_wdata),
    .port_ready(a_port_ready), .port_rdata(a_port_rdata),
    .port_rdata_valid(a_port_rdata_valid),
    .local_address(a_local_address), .local_size(a_local_size),
    .local_be(a_local_be), .local_wdata(a_local_wdata),
    .local_read_req(a_local_read_req), .local_write_req(a_local_write_req),
    .local_burstbegin(a_local_burstbegin),
    .local_ready(local_ready), .local_rdata(local_rdata),
    .local_rdata_valid(local_rdata_valid), .local_init_done(local_init_done),
    .grant_port(a_grant_port), .busy(a_busy), .rd_orphan_err(a_rd_orphan_err)
  );

  sdram_local_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW),
    .TAG_DEPTH(4), .PRIORITY_MODE(1)
  ) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .port_address(port_address), .port_read_req(port_read_req),
    .port_write_req(port_write_req), .port_size(port_size),
    .port_burstbegin(port_burstbegin), .port_be(port_be), .port_wdata(port_wdata),
    .port_ready(b_port_ready), .port_rdata(b_port_rdata),
    .port_rdata_valid(b_port_rdata_valid),
    .local_address(b_local_address), .local_size(b_local_size),
    .local_be(b_local_be), .local_wdata(b_local_wdata),
    .local_read_req(b_local_read_req), .local_write_req(b_local_write_req),
    .local_burstbegin(b_local_burstbegin),
    .local_ready(local_ready), .local_rdata(local_rdata),
    .local_rdata_valid(local_rdata_valid), .local_init_done(local_init_done),
    .grant_port(b_grant_port), .busy(b_busy), .rd_orphan_err(b_rd_orphan_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [SW-1:0] s,
                          input logic [DW-1:0] d);
    port_address[p*AW +: AW] = a;
    port_size[p*SW +: SW]    = s;
    port_wdata[p*DW +: DW]   = d;
    port_be[p*BW +: BW]      = '1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int n, n0, n3;
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    port_read_req = '0; port_write_req = '0; port_burstbegin = '0;
    port_address = '0; port_size = '0; port_be = '0; port_wdata = '0;
    local_ready = 1'b0; local_rdata_valid = 1'b0; local_init_done = 1'b0;
    local_rdata = '0;
    for (int i = 0; i < 4; i++) set_port(i, AW'(24'h100 + i), 3'd1, DW'(16'hA0A0 + i));

    // Reset state of every output on both instances
    repeat (2) cyc();
    check("rst_a_busy", a_busy, 0);           check("rst_b_busy", b_busy, 0);
    check("rst_a_rreq", a_local_read_req, 0); check("rst_b_rreq", b_local_read_req, 0);
    check("rst_a_wreq", a_local_write_req, 0); check("rst_b_wreq", b_local_write_req, 0);
    check("rst_a_bb", a_local_burstbegin, 0); check("rst_b_bb", b_local_burstbegin, 0);
    check("rst_a_ready", a_port_ready, 0);    check("rst_b_ready", b_port_ready, 0);
    check("rst_a_rv", a_port_rdata_valid, 0); check("rst_b_rv", b_port_rdata_valid, 0);
    check("rst_a_rdata", a_port_rdata, 0);    check("rst_b_rdata", b_port_rdata, 0);
    check("rst_a_addr", a_local_address, 0);  check("rst_b_addr", b_local_address, 0);
    check("rst_a_size", a_local_size, 0);     check("rst_b_size", b_local_size, 0);
    check("rst_a_be", a_local_be, 0);         check("rst_b_be", b_local_be, 0);
    check("rst_a_wdata", a_local_wdata, 0);   check("rst_b_wdata", b_local_wdata, 0);
    check("rst_a_grant", a_grant_port, 0);    check("rst_b_grant", b_grant_port, 0);
    check("rst_a_orph", a_rd_orphan_err, 0);  check("rst_b_orph", b_rd_orphan_err, 0);

    // Round-robin: four simultaneous size-1 writes grant 0,1,2,3
    do_reset();
    local_init_done = 1'b1;
    local_ready     = 1'b1;
    port_write_req  = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      cyc(); #1;
      check("rr_grant", a_grant_port, g);
      check("rr_wreq", a_local_write_req, 1);
      check("rr_bb", a_local_burstbegin, 1);
      check("rr_ready", a_port_ready, 64'd1 << g);
      check("rr_addr", a_local_address, 64'h100 + g);
      check("rr_wdata", a_local_wdata, 64'hA0A0 + g);
      check("rr_size", a_local_size, 1);
      cyc();
      port_write_req[g] = 1'b0;
      #1;
      check("rr_gap_busy", a_busy, 0);
      check("rr_gap_ready", a_port_ready, 0);
    end

    // Stalled size-4 write on port 2, ready low for 3 cycles on beat 2
    do_reset();
    set_port(2, 24'h222, 3'd4, 16'hB000);
    port_write_req = 4'b0100;
    cyc(); #1;
    check("st_grant0", a_grant_port, 2);
    check("st_bb0", a_local_burstbegin, 1);
    check("st_ready0", a_port_ready, 4'b0100);
    check("st_wdata0", a_local_wdata, 16'hB000);
    check("st_size", a_local_size, 4);
    cyc();
    port_wdata[2*DW +: DW] = 16'hB001;
    #1;
    check("st_bb1", a_local_burstbegin, 0);
    check("st_ready1", a_port_ready, 4'b0100);
    check("st_wdata1", a_local_wdata, 16'hB001);
    cyc();
    port_wdata[2*DW +: DW] = 16'hB002;
    local_ready = 1'b0;
    port_write_req[0] = 1'b1;
    #1;
    check("st_stall_ready", a_port_ready, 0);
    check("st_stall_wreq", a_local_write_req, 1);
    check("st_stall_bb", a_local_burstbegin, 0);
    repeat (2) begin
      cyc(); #1;
      check("st_stall_grant", a_grant_port, 2);
      check("st_stall_ready", a_port_ready, 0);
      check("st_stall_busy", a_busy, 1);
    end
    cyc();
    local_ready = 1'b1;
    #1;
    check("st_ready2", a_port_ready, 4'b0100);
    check("st_wdata2", a_local_wdata, 16'hB002);
    check("st_bb2", a_local_burstbegin, 0);
    cyc();
    port_wdata[2*DW +: DW] = 16'hB003;
    #1;
    check("st_ready3", a_port_ready, 4'b0100);
    check("st_wdata3", a_local_wdata, 16'hB003);
    check("st_grant3", a_grant_port, 2);
    cyc();
    port_write_req = '0;
    #1;
    check("st_done_busy", a_busy, 0);

    // Reads: port 1 size 2, then port 3 size 4, data returned back-to-back
    do_reset();
    set_port(1, 24'h101, 3'd2, 16'h0);
    set_port(3, 24'h103, 3'd4, 16'h0);
    port_read_req = 4'b1010;
    cyc(); #1;
    check("rd1_grant", a_grant_port, 1);
    check("rd1_rreq", a_local_read_req, 1);
    check("rd1_wreq", a_local_write_req, 0);
    check("rd1_bb", a_local_burstbegin, 1);
    check("rd1_size", a_local_size, 2);
    check("rd1_addr", a_local_address, 24'h101);
    check("rd1_ready", a_port_ready, 4'b0010);
    cyc();
    port_read_req[1] = 1'b0;
    #1;
    check("rd1_idle", a_busy, 0);
    cyc(); #1;
    check("rd3_grant", a_grant_port, 3);
    check("rd3_size", a_local_size, 4);
    check("rd3_addr", a_local_address, 24'h103);
    check("rd3_ready", a_port_ready, 4'b1000);
    cyc();
    port_read_req[3] = 1'b0;
    #1;
    check("rd3_idle", a_busy, 0);
    for (int k = 0; k < 6; k++) begin
      local_rdata_valid = 1'b1;
      local_rdata = DW'(16'hD000 + k);
      #1;
      check("ret_valid", a_port_rdata_valid, (k < 2) ? 4'b0010 : 4'b1000);
      check("ret_data", a_port_rdata, 16'hD000 + k);
      cyc();
    end
    local_rdata_valid = 1'b0;
    #1;
    check("ret_after_valid", a_port_rdata_valid, 0);
    check("ret_no_orphan", a_rd_orphan_err, 0);

    // Orphan beat: FIFO is empty now, so the beat is dropped and flagged
    local_rdata_valid = 1'b1;
    #1;
    check("orph_valid", a_port_rdata_valid, 0);
    check("orph_data", a_port_rdata, 0);
    cyc();
    local_rdata_valid = 1'b0;
    #1;
    check("orph_set", a_rd_orphan_err, 1);
    repeat (2) cyc();
    check("orph_sticky", a_rd_orphan_err, 1);

    // Reset asserted in the middle of a size-4 write on port 1
    set_port(1, 24'h111, 3'd4, 16'hC001);
    port_write_req = 4'b0010;
    cyc(); #1;
    check("mr_grant", a_grant_port, 1);
    check("mr_bb0", a_local_burstbegin, 1);
    cyc(); #1;
    check("mr_busy", a_busy, 1);
    check("mr_bb1", a_local_burstbegin, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_busy_rst", a_busy, 0);
    check("mr_wreq_rst", a_local_write_req, 0);
    check("mr_bb_rst", a_local_burstbegin, 0);
    check("mr_ready_rst", a_port_ready, 0);
    check("mr_addr_rst", a_local_address, 0);
    check("mr_wdata_rst", a_local_wdata, 0);
    check("mr_size_rst", a_local_size, 0);
    check("mr_grant_rst", a_grant_port, 0);
    check("mr_orph_rst", a_rd_orphan_err, 0);
    port_write_req = '0;
    cyc();
    reset_n = 1'b1;
    cyc();

    // Tag limit: 5 size-1 reads from port 0 with only 4 tags
    do_reset();
    set_port(0, 24'h100, 3'd1, 16'h0);
    port_read_req = 4'b0001;
    n = 0;
    repeat (10) begin
      cyc();
      if (a_port_ready[0]) n++;
    end
    check("tag_accepts", n, 4);
    check("tag_held_idle", a_busy, 0);
    local_rdata_valid = 1'b1;
    local_rdata = 16'hE000;
    #1;
    check("tag_ret_valid", a_port_rdata_valid, 4'b0001);
    cyc();
    local_rdata_valid = 1'b0;
    n = 0;
    repeat (4) begin
      cyc();
      if (a_port_ready[0]) n++;
    end
    check("tag_after_pop", n, 1);
    port_read_req = '0;

    // Init gating, then fixed priority starves port 3
    do_reset();
    local_init_done = 1'b0;
    set_port(0, 24'h100, 3'd1, 16'h0);
    set_port(3, 24'h103, 3'd1, 16'h0);
    port_write_req = 4'b1001;
    n = 0;
    repeat (5) begin
      cyc();
      if (b_busy || b_local_write_req || a_busy) n++;
    end
    check("init_gate", n, 0);
    local_init_done = 1'b1;
    n0 = 0;
    n3 = 0;
    repeat (10) begin
      cyc();
      if (b_port_ready[0]) n0++;
      if (b_port_ready[3]) n3++;
    end
    check("fp_port0", n0, 5);
    check("fp_port3", n3, 0);
    port_write_req = '0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
